// File: rtl/reorder_buffer_pkg.sv
// Shared constants and entry layout for the reorder buffer.
// Id 0 means "no producer", so only ids 1..ROB_SIZE are ever handed out.
package reorder_buffer_pkg;
   localparam int ID_W     = 4;
   localparam int ROB_SIZE = (1 << ID_W) - 1;
   localparam logic [ID_W-1:0] ROB_LAST = ID_W'(ROB_SIZE);

   typedef enum logic [1:0] {
      ROB_T_REG    = 2'd0,
      ROB_T_BRANCH = 2'd1,
      ROB_T_STORE  = 2'd2
   } rob_type_e;

   typedef struct packed {
      logic        busy;
      logic        ready;
      rob_type_e   rtype;
      logic [4:0]  rd;
      logic [31:0] value;
      logic        pred_taken;
      logic [31:0] alt_pc;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_rob_id_inc.sv
// Advances a ROB pointer by one, wrapping ROB_SIZE back to 1 so that id 0
// is never produced.
module rob_id_inc
   import reorder_buffer_pkg::*;
(
   input  logic [ID_W-1:0] id,
   output logic [ID_W-1:0] id_next
);
   assign id_next = (id == ROB_LAST) ? ID_W'(1) : id + ID_W'(1);
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order completion buffer: allocates ROB ids, captures CDB results,
// retires in program order and flushes everything on a branch mispredict.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            issue_valid,
   input  logic [1:0]      issue_type,
   input  logic [4:0]      issue_rd,
   input  logic            issue_pred_taken,
   input  logic [31:0]     issue_alt_pc,
   output logic [ID_W-1:0] issue_rob_id,
   output logic            rob_full,
   output logic            rob_one_left,
   input  logic [ID_W-1:0] cdb_alu_rob_id,
   input  logic [31:0]     cdb_alu_value,
   input  logic [ID_W-1:0] cdb_mem_rob_id,
   input  logic [31:0]     cdb_mem_value,
   input  logic [ID_W-1:0] query_j_id,
   output logic            query_j_ready,
   output logic [31:0]     query_j_value,
   input  logic [ID_W-1:0] query_k_id,
   output logic            query_k_ready,
   output logic [31:0]     query_k_value,
   output logic            commit_valid,
   output logic [4:0]      commit_rd,
   output logic [31:0]     commit_value,
   output logic [ID_W-1:0] commit_rob_id,
   output logic            commit_store,
   output logic            flush_out,
   output logic [31:0]     redirect_pc
);
   // Slot 0 exists only so any id can index the array; it is never allocated.
   rob_entry_t      entry [0:(1<<ID_W)-1];
   rob_entry_t      head_entry;
   logic [ID_W-1:0] head, tail, head_next, tail_next, count, count_next;
   logic            do_commit, mispredict, issue_ok, commit_reg, commit_st;

   rob_id_inc u_head_inc (.id(head), .id_next(head_next));
   rob_id_inc u_tail_inc (.id(tail), .id_next(tail_next));

   assign issue_rob_id = tail;

   always_comb begin
      head_entry = entry[head];
      do_commit  = head_entry.busy && head_entry.ready;
      commit_reg = do_commit && (head_entry.rtype == ROB_T_REG);
      commit_st  = do_commit && (head_entry.rtype == ROB_T_STORE);
      mispredict = do_commit && (head_entry.rtype == ROB_T_BRANCH) &&
                   (head_entry.value[0] != head_entry.pred_taken);
      issue_ok   = issue_valid && (count != ROB_LAST);
      if (mispredict)
         count_next = '0;
      else
         count_next = count + ID_W'(issue_ok) - ID_W'(do_commit);
   end

   // Results still on the CDB are forwarded so a consumer need not wait a cycle.
   function automatic logic [32:0] lookup(input logic [ID_W-1:0] id);
      if (id == '0)             return {1'b1, 32'd0};
      if (id == cdb_alu_rob_id) return {1'b1, cdb_alu_value};
      if (id == cdb_mem_rob_id) return {1'b1, cdb_mem_value};
      return {entry[id].ready, entry[id].value};
   endfunction

   assign {query_j_ready, query_j_value} = lookup(query_j_id);
   assign {query_k_ready, query_k_value} = lookup(query_k_id);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < (1 << ID_W); i++) entry[i] <= '0;
         head          <= ID_W'(1);
         tail          <= ID_W'(1);
         count         <= '0;
         rob_full      <= 1'b0;
         rob_one_left  <= 1'b0;
         commit_valid  <= 1'b0;
         commit_rd     <= '0;
         commit_value  <= '0;
         commit_rob_id <= '0;
         commit_store  <= 1'b0;
         flush_out     <= 1'b0;
         redirect_pc   <= '0;
      end else begin
         // Retire-side outputs read 0 in cycles without the matching event.
         commit_valid  <= commit_reg;
         commit_rd     <= commit_reg ? head_entry.rd : '0;
         commit_value  <= commit_reg ? head_entry.value : '0;
         commit_store  <= commit_st;
         commit_rob_id <= do_commit ? head : '0;
         flush_out     <= mispredict;
         redirect_pc   <= mispredict ? head_entry.alt_pc : '0;
         rob_full      <= (count_next == ROB_LAST);
         rob_one_left  <= (count_next == ROB_LAST - ID_W'(1));
         count         <= count_next;
         if (mispredict) begin
            for (int i = 0; i < (1 << ID_W); i++) entry[i] <= '0;
            head <= ID_W'(1);
            tail <= ID_W'(1);
         end else begin
            // ALU write comes last so it wins when both buses name the same id.
            if (cdb_mem_rob_id != '0 && entry[cdb_mem_rob_id].busy) begin
               entry[cdb_mem_rob_id].ready <= 1'b1;
               entry[cdb_mem_rob_id].value <= cdb_mem_value;
            end
            if (cdb_alu_rob_id != '0 && entry[cdb_alu_rob_id].busy) begin
               entry[cdb_alu_rob_id].ready <= 1'b1;
               entry[cdb_alu_rob_id].value <= cdb_alu_value;
            end
            if (do_commit) begin
               entry[head].busy  <= 1'b0;
               entry[head].ready <= 1'b0;
               head              <= head_next;
            end
            if (issue_ok) begin
               entry[tail] <= '{busy: 1'b1, ready: 1'b0, rtype: rob_type_e'(issue_type),
                                rd: issue_rd, value: 32'd0,
                                pred_taken: issue_pred_taken, alt_pc: issue_alt_pc};
               tail <= tail_next;
            end
         end
      end
   end
endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic, all compared
// against a queue-based program-order model of the buffer.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic            issue_valid;
   logic [1:0]      issue_type;
   logic [4:0]      issue_rd;
   logic            issue_pred_taken;
   logic [31:0]     issue_alt_pc;
   logic [ID_W-1:0] issue_rob_id;
   logic            rob_full, rob_one_left;
   logic [ID_W-1:0] cdb_alu_rob_id, cdb_mem_rob_id, query_j_id, query_k_id, commit_rob_id;
   logic [31:0]     cdb_alu_value, cdb_mem_value, query_j_value, query_k_value;
   logic [31:0]     commit_value, redirect_pc;
   logic            query_j_ready, query_k_ready, commit_valid, commit_store, flush_out;
   logic [4:0]      commit_rd;

   always #5 clk_in = ~clk_in;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
      .issue_rob_id(issue_rob_id), .rob_full(rob_full), .rob_one_left(rob_one_left),
      .cdb_alu_rob_id(cdb_alu_rob_id), .cdb_alu_value(cdb_alu_value),
      .cdb_mem_rob_id(cdb_mem_rob_id), .cdb_mem_value(cdb_mem_value),
      .query_j_id(query_j_id), .query_j_ready(query_j_ready), .query_j_value(query_j_value),
      .query_k_id(query_k_id), .query_k_ready(query_k_ready), .query_k_value(query_k_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_rob_id(commit_rob_id), .commit_store(commit_store),
      .flush_out(flush_out), .redirect_pc(redirect_pc)
   );

   // Model: in-flight instructions in program order, oldest first.
   typedef struct {
      int          id;
      int          typ;
      int          rd;
      bit          pred;
      logic [31:0] alt;
      bit          rdy;
      logic [31:0] val;
   } ment_t;

   ment_t       rob[$];
   int          next_id = 1;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] e_cv, e_rd, e_val, e_cid, e_cs, e_fl, e_pc, e_full, e_one;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_query(input logic [3:0] id, output bit r, output logic [31:0] v);
      r = 1'b0;
      v = '0;
      if (id == 4'd0) r = 1'b1;
      else if (cdb_alu_rob_id == id) begin r = 1'b1; v = cdb_alu_value; end
      else if (cdb_mem_rob_id == id) begin r = 1'b1; v = cdb_mem_value; end
      else foreach (rob[i]) if (rob[i].id == int'(id)) begin r = rob[i].rdy; v = rob[i].val; end
   endfunction

   function automatic void model_edge();
      bit    commit, mis, issue;
      ment_t n;
      {e_cv, e_rd, e_val, e_cid, e_cs, e_fl, e_pc} = '0;
      if (rst_in) begin
         rob.delete();
         next_id = 1;
      end else begin
         commit = rob.size() > 0 && rob[0].rdy;
         mis    = commit && rob[0].typ == 1 && (rob[0].val[0] != rob[0].pred);
         issue  = issue_valid && rob.size() < ROB_SIZE;
         if (commit) begin
            e_cid = rob[0].id;
            if (rob[0].typ == 0) begin e_cv = 1; e_rd = rob[0].rd; e_val = rob[0].val; end
            if (rob[0].typ == 2) e_cs = 1;
            if (mis) begin e_fl = 1; e_pc = rob[0].alt; end
         end
         if (mis) begin
            rob.delete();
            next_id = 1;
         end else begin
            foreach (rob[i]) begin
               if (cdb_alu_rob_id != 0 && rob[i].id == int'(cdb_alu_rob_id)) begin
                  rob[i].rdy = 1; rob[i].val = cdb_alu_value;
               end else if (cdb_mem_rob_id != 0 && rob[i].id == int'(cdb_mem_rob_id)) begin
                  rob[i].rdy = 1; rob[i].val = cdb_mem_value;
               end
            end
            if (commit) void'(rob.pop_front());
            if (issue) begin
               n.id = next_id; n.typ = int'(issue_type); n.rd = int'(issue_rd);
               n.pred = issue_pred_taken; n.alt = issue_alt_pc; n.rdy = 0; n.val = '0;
               rob.push_back(n);
               next_id = (next_id == ROB_SIZE) ? 1 : next_id + 1;
            end
         end
      end
      e_full = 32'(rob.size() == ROB_SIZE);
      e_one  = 32'(rob.size() == ROB_SIZE - 1);
   endfunction

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic step();
      bit          r;
      logic [31:0] v;
      #1;
      check("issue_rob_id", 32'(issue_rob_id), 32'(next_id));
      model_query(query_j_id, r, v);
      check("query_j_ready", 32'(query_j_ready), 32'(r));
      if (r) check("query_j_value", query_j_value, v);
      model_query(query_k_id, r, v);
      check("query_k_ready", 32'(query_k_ready), 32'(r));
      if (r) check("query_k_value", query_k_value, v);
      model_edge();
      @(posedge clk_in);
      #1;
      check("commit_valid", 32'(commit_valid), e_cv);
      check("commit_rd", 32'(commit_rd), e_rd);
      check("commit_value", commit_value, e_val);
      check("commit_rob_id", 32'(commit_rob_id), e_cid);
      check("commit_store", 32'(commit_store), e_cs);
      check("flush_out", 32'(flush_out), e_fl);
      check("redirect_pc", redirect_pc, e_pc);
      check("rob_full", 32'(rob_full), e_full);
      check("rob_one_left", 32'(rob_one_left), e_one);
   endtask

   task automatic idle();
      issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pred_taken = 0; issue_alt_pc = 0;
      cdb_alu_rob_id = 0; cdb_alu_value = 0; cdb_mem_rob_id = 0; cdb_mem_value = 0;
      query_j_id = 0; query_k_id = 0;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic p, input logic [31:0] alt);
      idle();
      issue_valid = 1; issue_type = t; issue_rd = rd; issue_pred_taken = p; issue_alt_pc = alt;
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1;
      step();
      rst_in = 0;
   endtask

   function automatic logic [3:0] pick_id(input int pct);
      if ($urandom_range(99) >= pct) return 4'd0;
      if (rob.size() > 0 && $urandom_range(99) < 75)
         return 4'(rob[$urandom_range(rob.size() - 1)].id);
      return 4'($urandom_range(15));
   endfunction

   // Mostly confirm branch predictions so the buffer can fill between flushes.
   function automatic logic [31:0] bias(input logic [3:0] id, input logic [31:0] v);
      logic [31:0] o = v;
      foreach (rob[i])
         if (rob[i].id == int'(id) && rob[i].typ == 1 && $urandom_range(99) < 85) o[0] = rob[i].pred;
      return o;
   endfunction

   task automatic rand_inputs(input int pct);
      int s;
      issue_valid      = 1'($urandom_range(99) < 60);
      issue_type       = 2'($urandom_range(2));
      issue_rd         = 5'($urandom);
      issue_pred_taken = 1'($urandom);
      issue_alt_pc     = $urandom;
      cdb_alu_rob_id   = pick_id(pct);
      cdb_alu_value    = bias(cdb_alu_rob_id, $urandom);
      if ($urandom_range(99) < 10) cdb_mem_rob_id = cdb_alu_rob_id;
      else cdb_mem_rob_id = pick_id(pct);
      cdb_mem_value    = bias(cdb_mem_rob_id, $urandom);
      s = int'($urandom_range(9));
      query_j_id = (s < 3) ? cdb_alu_rob_id : (s < 5) ? cdb_mem_rob_id : 4'($urandom_range(15));
      s = int'($urandom_range(9));
      query_k_id = (s < 3) ? cdb_alu_rob_id : (s < 5) ? cdb_mem_rob_id : 4'($urandom_range(15));
   endtask

   initial begin
      idle();
      rst_in = 1;
      repeat (2) @(posedge clk_in);
      #1;
      do_reset();

      // In-order retirement despite out-of-order completion.
      issue(ROB_T_REG, 5'd5, 0, 0); step();
      issue(ROB_T_REG, 5'd6, 0, 0); step();
      issue(ROB_T_REG, 5'd7, 0, 0); step();
      idle(); cdb_alu_rob_id = 2; cdb_alu_value = 32'h22; step();
      idle(); cdb_alu_rob_id = 1; cdb_alu_value = 32'h11; step();
      idle(); step();
      check("t1_rd5", 32'(commit_rd), 32'd5);
      check("t1_val5", commit_value, 32'h11);
      step();
      check("t1_rd6", 32'(commit_rd), 32'd6);
      check("t1_val6", commit_value, 32'h22);

      // Fill to capacity, overflow drop, then wrap past id 0.
      do_reset();
      for (int i = 1; i <= ROB_SIZE; i++) begin
         issue(ROB_T_REG, 5'(i), 0, 0);
         step();
         if (i == ROB_SIZE - 1) check("t2_one_left", 32'(rob_one_left), 32'd1);
      end
      check("t2_full", 32'(rob_full), 32'd1);
      issue(ROB_T_REG, 5'd31, 0, 0); step();
      check("t2_tail_held", 32'(issue_rob_id), 32'd1);
      idle(); cdb_alu_rob_id = 1; cdb_alu_value = 32'h5; step();
      idle(); step();
      issue(ROB_T_REG, 5'd3, 0, 0);
      #1 check("t2_wrap_id", 32'(issue_rob_id), 32'd1);
      step();

      // CDB forwarding on query, and the id 0 constant.
      idle(); query_j_id = 4; query_k_id = 0; cdb_mem_rob_id = 4; cdb_mem_value = 32'hDEAD;
      #1;
      check("t3_j_ready", 32'(query_j_ready), 32'd1);
      check("t3_j_value", query_j_value, 32'hDEAD);
      check("t3_k_ready", 32'(query_k_ready), 32'd1);
      check("t3_k_value", query_k_value, 32'd0);
      step();

      // Mispredict flush drops younger work and same-cycle issue/CDB.
      do_reset();
      issue(ROB_T_BRANCH, 5'd0, 0, 32'h100); step();
      issue(ROB_T_REG, 5'd9, 0, 0); step();
      idle(); cdb_alu_rob_id = 1; cdb_alu_value = 32'h1; step();
      issue(ROB_T_REG, 5'd10, 0, 0); cdb_alu_rob_id = 2; cdb_alu_value = 32'h7; step();
      check("t4_flush", 32'(flush_out), 32'd1);
      check("t4_redirect", redirect_pc, 32'h100);
      idle(); step();
      check("t4_flush_low", 32'(flush_out), 32'd0);
      check("t4_id_reset", 32'(issue_rob_id), 32'd1);
      check("t4_not_full", 32'(rob_full), 32'd0);
      step();

      // Store retirement.
      do_reset();
      issue(ROB_T_STORE, 5'd0, 0, 0); step();
      idle(); cdb_mem_rob_id = 1; cdb_mem_value = 32'h0; step();
      idle(); step();
      check("t5_store", 32'(commit_store), 32'd1);
      check("t5_store_id", 32'(commit_rob_id), 32'd1);
      check("t5_no_valid", 32'(commit_valid), 32'd0);

      // Random traffic with varying CDB density.
      for (int c = 0; c < 3000; c++) begin
         rand_inputs((c / 200) % 3 == 0 ? 70 : (c / 200) % 3 == 1 ? 30 : 5);
         step();
      end

      // Reset with work in flight and a live CDB.
      do_reset();
      for (int i = 0; i < 5; i++) begin issue(ROB_T_REG, 5'(i + 1), 0, 0); step(); end
      idle(); cdb_alu_rob_id = 1; cdb_alu_value = 32'h3;
      issue_valid = 1; rst_in = 1; step(); rst_in = 0;
      check("t6_id", 32'(issue_rob_id), 32'd1);
      check("t6_valid", 32'(commit_valid), 32'd0);
      idle(); step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order completion buffer that allocates the ROB ids carried as dest/Qj/Qk by the dispatcher and reservation stations.
- Sinks the ALU and memory CDB broadcasts and marks entries ready.
- Retires entries in program order to the register file and store unit.
- Raises the pipeline flush on a mispredicted branch; this flush drives flush_input of the reservation stations.

Parameters:
ID_W, 4, ROB id width; equals width of `ROB_RANGE.
ROB_SIZE, 15, usable entries (2^ID_W - 1); id 0 is reserved as "invalid/none".

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
issue_valid  input  1  allocate one entry this cycle
issue_type  input  2  ROB_T_REG / ROB_T_BRANCH / ROB_T_STORE
issue_rd  input  5  destination architectural register
issue_pred_taken  input  1  branch prediction used at fetch
issue_alt_pc  input  32  PC to redirect to if the prediction is wrong
issue_rob_id  output  ID_W  id that the current issue receives (combinational = tail)
rob_full  output  1  registered; no vacancy
rob_one_left  output  1  registered; exactly one vacancy
cdb_alu_rob_id  input  ID_W  ALU broadcast id (0 = none)
cdb_alu_value  input  32  ALU broadcast value
cdb_mem_rob_id  input  ID_W  memory broadcast id (0 = none)
cdb_mem_value  input  32  memory broadcast value
query_j_id  input  ID_W  operand-j lookup id
query_j_ready  output  1  combinational
query_j_value  output  32  combinational
query_k_id  input  ID_W  operand-k lookup id
query_k_ready  output  1  combinational
query_k_value  output  32  combinational
commit_valid  output  1  registered one-cycle pulse; register write retire
commit_rd  output  5  register to write
commit_value  output  32  value to write
commit_rob_id  output  ID_W  id being retired (all types)
commit_store  output  1  registered pulse; store at head may write memory
flush_out  output  1  registered pulse; mispredict flush
redirect_pc  output  32  valid while flush_out is 1

Behaviour:
- Storage per entry: busy, ready, type, rd, value, pred_taken, alt_pc.
- Pointers: head (oldest) and tail (next free), each in range 1..ROB_SIZE.
- Increment wraps ROB_SIZE -> 1, never producing 0.
- Count: 0..ROB_SIZE.

Reset (rst_in=1 at posedge):
- All busy/ready cleared; head=tail=1; count=0.
- All registered outputs 0; issue_rob_id therefore reads 1.

Issue:
- Accepted when issue_valid && count<ROB_SIZE.
- Writes the entry at tail: busy=1, ready=0, plus the issue fields. tail advances.
- issue_valid while full is dropped; state unchanged.

CDB:
- For each busy entry whose id equals a nonzero cdb id: ready<=1 and value<=cdb value.
- If both buses carry the same id, ALU wins.
- Ids naming non-busy entries are ignored.

Query (combinational):
- id 0 -> ready=1, value=0.
- Else, if a CDB bus carries the id this cycle -> ready=1 with that bus value (ALU priority).
- Else -> entry's ready/value.

Commit (at most one per cycle):
- Occurs when the head entry is busy && ready. Ready is the registered flag, so CDB at cycle t enables commit at t+1.
- REG: commit_valid=1, commit_rd, commit_value.
- STORE: commit_store=1.
- BRANCH: taken=value[0]; on a match, plain retire with no pulse.
- commit_rob_id = head for all types; head advances and busy is cleared.

Mispredict (branch at head, value[0]!=pred_taken):
- At that edge, flush_out=1 and redirect_pc=alt_pc.
- Every entry is cleared; head=tail=1; count=0.
- A same-cycle issue is dropped, as are all same-cycle CDB writes.
- Next cycle flush_out returns to 0.

Simultaneous issue+commit: count unchanged, both pointers advance.

Flags:
- rob_full and rob_one_left are computed from the post-update count and registered.
- Both are 0 after a flush.

Decomposition:
- const_def.v: ROB_RANGE, ROB_SIZE, ROB_T_REG=0, ROB_T_BRANCH=1, ROB_T_STORE=2.
- Sub-module rob_id_inc: wrap-increment skipping 0; used for head and tail.

Test Plan:
1. Reset, then issue 3 REG (rd=5,6,7) -> issue_rob_id 1,2,3; ALU CDB id2=0x22, then id1=0x11 -> commits in order: rd5=0x11 one cycle after id1's CDB, rd6=0x22 the cycle after.
2. Issue 15 entries -> rob_full=1 (rob_one_left=1 after the 14th); 16th issue ignored, tail stays 1; commit one -> next issue gets id 1 (wrap, 0 skipped).
3. Query id 4 while cdb_mem_rob_id=4, value 0xDEAD -> query_j_ready=1 and value 0xDEAD in the same cycle; query id 0 -> ready=1, value=0.
4. Branch id1 pred_taken=0, alt_pc=0x100; REG id2 issued; CDB id1 value=1 -> flush_out pulse with redirect_pc=0x100; id2 never commits; next issue_rob_id=1, rob_full=0.
5. STORE at head; mem CDB for its id -> commit_store pulse one cycle later with commit_rob_id = store id, commit_valid=0.
6. Assert rst_in with 5 entries in flight and a CDB active -> next cycle all outputs 0, no commit pulses, issue_rob_id=1.
